// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer:
// FSM states, opcode classes, opcode constants, ALU op and mux select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC,
    C_ILLEGAL
  } opc_class_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_OR    = 5'd2;
  localparam logic [4:0] ALU_XOR   = 5'd3;
  localparam logic [4:0] ALU_AND   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_PASSB = 5'd8;
  localparam logic [4:0] ALU_SLT   = 5'd9;
  localparam logic [4:0] ALU_SLTU  = 5'd10;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;
  localparam logic [1:0] PC_TRAP   = 2'd3;

  localparam logic [1:0] Y_ALU = 2'd0;
  localparam logic [1:0] Y_MEM = 2'd1;
  localparam logic [1:0] Y_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_MEM_TO  = 2'd1;

  function automatic opc_class_t decode_class(input logic [6:0] opc);
    opc_class_t cls;
    case (opc)
      OPC_R:      cls = C_R;
      OPC_I:      cls = C_I;
      OPC_LOAD:   cls = C_LOAD;
      OPC_STORE:  cls = C_STORE;
      OPC_BRANCH: cls = C_BRANCH;
      OPC_JAL:    cls = C_JAL;
      OPC_JALR:   cls = C_JALR;
      OPC_LUI:    cls = C_LUI;
      OPC_AUIPC:  cls = C_AUIPC;
      default:    cls = C_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_seq_if.sv
// Bundle between the control sequencer (master) and the datapath/memory side (slave).
interface control_seq_if #(
  parameter int XLEN = 32
);
  // mem_rd/mem_wr are requests held high until the cycle mem_ack=1 is seen;
  // that cycle completes the access. mem_ack with no request pending is ignored.
  logic [31:0]     ins;
  logic            mem_ack;
  logic            br_taken;
  logic [XLEN-1:0] imm;
  logic [4:0]      alu_op;
  logic            a_sel;
  logic            b_sel;
  logic [1:0]      y_sel;
  logic [1:0]      pc_sel;
  logic            pc_en;
  logic            ir_en;
  logic            rf_wr;
  logic            mem_rd;
  logic            mem_wr;
  logic [1:0]      mem_size;
  logic            trap;
  logic [1:0]      trap_cause;
  logic            instr_done;

  modport master (
    input  ins, mem_ack, br_taken,
    output imm, alu_op, a_sel, b_sel, y_sel, pc_sel, pc_en, ir_en, rf_wr,
           mem_rd, mem_wr, mem_size, trap, trap_cause, instr_done
  );

  modport slave (
    output ins, mem_ack, br_taken,
    input  imm, alu_op, a_sel, b_sel, y_sel, pc_sel, pc_en, ir_en, rf_wr,
           mem_rd, mem_wr, mem_size, trap, trap_cause, instr_done
  );
endinterface

// File: rtl/control_seq_imm_gen.sv
// Immediate decoder: builds the format-specific immediate for the opcode class
// and sign-extends it from ins[31] to XLEN.
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins,
  input  opc_class_t      cls,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (cls)
      C_I, C_LOAD, C_JALR: imm32 = {{20{ins[31]}}, ins[31:20]};
      C_STORE:             imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      C_BRANCH:            imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      C_JAL:               imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      C_LUI, C_AUIPC:      imm32 = {ins[31:12], 12'b0};
      default:             imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/control_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a trap path
// for illegal opcodes and memory-wait timeouts. Outputs decode from state and ins.
module control_seq
  import ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MEM_TO = 255
) (
  input  logic          clk,
  input  logic          rst,
  control_seq_if.master bus,
  output state_t        dbg_state
);

  localparam int CW = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (MEM_TO > 0) ? CW'(MEM_TO - 1) : '0;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic            br_q;
  logic [1:0]      cause_q;
  opc_class_t      cls;
  logic [XLEN-1:0] imm_dec;
  logic [4:0]      alu_dec;
  logic            is_mem;
  logic            timed_out;

  assign cls       = decode_class(bus.ins[6:0]);
  assign is_mem    = (cls == C_LOAD) || (cls == C_STORE);
  assign dbg_state = state;
  // An ack in the final allowed cycle wins over the timeout.
  assign timed_out = (MEM_TO != 0) && !bus.mem_ack && (wait_cnt == CNT_LAST);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ins (bus.ins),
    .cls (cls),
    .imm (imm_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RESET;
      wait_cnt <= '0;
      br_q     <= 1'b0;
      cause_q  <= CAUSE_ILLEGAL;
    end else begin
      case (state)
        ST_RESET: begin
          state    <= ST_FETCH;
          wait_cnt <= '0;
        end
        ST_FETCH, ST_MEM: begin
          if (bus.mem_ack) begin
            state <= (state == ST_FETCH) ? ST_DECODE : ST_WB;
          end else if (timed_out) begin
            state   <= ST_TRAP;
            cause_q <= CAUSE_MEM_TO;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_DECODE: begin
          if (cls == C_ILLEGAL) begin
            state   <= ST_TRAP;
            cause_q <= CAUSE_ILLEGAL;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          br_q <= bus.br_taken;
          if (is_mem) begin
            state    <= ST_MEM;
            wait_cnt <= '0;
          end else begin
            state <= ST_WB;
          end
        end
        ST_WB, ST_TRAP: begin
          state    <= ST_FETCH;
          wait_cnt <= '0;
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  always_comb begin
    alu_dec = ALU_ADD;
    case (cls)
      C_BRANCH: alu_dec = ALU_SUB;
      C_LUI:    alu_dec = ALU_PASSB;
      C_R, C_I: begin
        case (bus.ins[14:12])
          3'b000:  alu_dec = (cls == C_R && bus.ins[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_dec = ALU_SLL;
          3'b010:  alu_dec = ALU_SLT;
          3'b011:  alu_dec = ALU_SLTU;
          3'b100:  alu_dec = ALU_XOR;
          3'b101:  alu_dec = bus.ins[30] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_dec = ALU_OR;
          default: alu_dec = ALU_AND;
        endcase
      end
      default:  alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    bus.imm        = '0;
    bus.alu_op     = ALU_ADD;
    bus.a_sel      = 1'b0;
    bus.b_sel      = 1'b0;
    bus.y_sel      = Y_ALU;
    bus.pc_sel     = PC_PLUS4;
    bus.pc_en      = 1'b0;
    bus.ir_en      = 1'b0;
    bus.rf_wr      = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_size   = 2'b00;
    bus.trap       = 1'b0;
    bus.trap_cause = 2'b00;
    bus.instr_done = 1'b0;
    // Decoded controls are only meaningful once IR holds the instruction.
    if (state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
      bus.imm    = imm_dec;
      bus.alu_op = alu_dec;
      bus.a_sel  = (cls == C_AUIPC);
      bus.b_sel  = cls inside {C_I, C_LOAD, C_STORE, C_JALR, C_LUI, C_AUIPC};
      if (cls == C_LOAD)
        bus.y_sel = Y_MEM;
      else if (cls == C_JAL || cls == C_JALR)
        bus.y_sel = Y_PC4;
    end
    case (state)
      ST_FETCH: begin
        bus.mem_rd   = 1'b1;
        bus.mem_size = 2'b10;
        bus.ir_en    = bus.mem_ack;
      end
      ST_MEM: begin
        bus.mem_rd   = (cls == C_LOAD);
        bus.mem_wr   = (cls == C_STORE);
        bus.mem_size = bus.ins[13:12];
      end
      ST_WB: begin
        bus.pc_en      = 1'b1;
        bus.instr_done = 1'b1;
        bus.rf_wr      = cls inside {C_R, C_I, C_LOAD, C_JAL, C_JALR, C_LUI, C_AUIPC};
        if (cls == C_JAL || (cls == C_BRANCH && br_q))
          bus.pc_sel = PC_BRANCH;
        else if (cls == C_JALR)
          bus.pc_sel = PC_ALU;
      end
      ST_TRAP: begin
        bus.pc_en      = 1'b1;
        bus.pc_sel     = PC_TRAP;
        bus.trap       = 1'b1;
        bus.trap_cause = cause_q;
      end
      default: ;
    endcase
  end

endmodule
